fas_pts: RTL and testbench
==========================

Name: fas_pts

Overview:
- Parallel-to-serial converter. It is the counterpart of the FAS serial-to-parallel stage.
- Takes one 16-lane frame per handshake from the FFT output side (32-bit lanes, {real16, imag16}) and streams the lanes out one per cycle, lane 0 first.
- Ping-pong buffered, so the next frame is captured while the current one drains. This sustains one lane per cycle.
- Sits between the FFT and any serial consumer: output port or analyst path.

Parameters:
- N, 16, lanes per frame (power of two, >=2)
- W, 32, bits per lane

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- clr  in  1  synchronous clear: drops all buffered data, same end state as reset
- in_valid  in  1  frame present on in_data
- in_ready  out  1  block can accept a frame this cycle
- in_data  in  N*W  lane i at bits [i*W +: W]
- out_valid  out  1  out_data holds a valid lane
- out_ready  in  1  downstream accepts the lane this cycle
- out_data  out  W  current lane value
- out_idx  out  log2(N)  lane index of out_data
- out_last  out  1  out_valid and out_idx==N-1

Behaviour:
- State registers: two frame buffers buf[0..1] (N×W each), wptr (1b), rptr (1b), cnt (0..2, number of full buffers), idx (log2(N) bits).
- Reset (rst=0, async) and clr=1 (sync) both set every state register and buffer to 0.
- Resulting outputs after reset/clr: out_valid=0, out_last=0, out_idx=0, out_data=0, in_ready=1.
- rst has priority over clr; clr has priority over every transfer in the same cycle.
- in_ready = (cnt<2). It is decoded from registers only; there is no combinational path from out_ready or in_valid.
- Accept = in_valid & in_ready.
  - On accept, all N lanes are registered into buf[wptr] at the edge, then wptr toggles.
  - in_data is don't-care when not accepted.
- out_valid = (cnt!=0). out_data = buf[rptr][idx]. out_idx = idx.
  - Outputs are combinational decode of registers; no input-to-output combinational path.
- Beat = out_valid & out_ready.
  - On a beat with idx<N-1: idx increments.
  - On a beat with idx==N-1: idx returns to 0, rptr toggles, and the buffer is released.
- cnt update per cycle:
  - +1 on accept only.
  - -1 on release only.
  - Unchanged when accept and release occur in the same cycle, or when neither occurs.
- Latency: a frame accepted at edge k gives out_valid=1 with lane 0 in the cycle after edge k, if no earlier frame is pending.
  - Minimum N cycles per frame at out_ready=1.
  - Back-to-back frames stream without bubbles.
- Backpressure: while out_ready=0, idx, out_data, out_idx and out_last hold. No lane is dropped or duplicated.
- Full (cnt=2): in_ready=0 until the edge that releases the older buffer. in_ready=1 in the following cycle.
- Empty (cnt=0): out_ready is ignored and idx stays 0.
- Wrap-around: wptr and rptr are 1-bit and toggle freely. Ordering is guaranteed by cnt.
- Buffers are not cleared on release; stale data is masked by out_valid=0.
- Reset mid-frame discards the partial frame. The next accepted frame starts at idx 0 from buf[0].

Decomposition:
- Shared package fas_pkg holds:
  - FAS_N=16 and FAS_W=32
  - FAS_IDX_W=$clog2(FAS_N)
  - lane type (signed [W-1:0] with real/imag halves)
  - the lane-slicing helper used by both the serial-to-parallel stage and this block
- One natural sub-module, fas_pts_frame_buf:
  - Contains one N×W register bank, a load enable, a full-width write port and a read mux by index.
  - Instantiated twice, selected by wptr/rptr.
  - Counters, pointers and handshake logic stay in fas_pts.

Test Plan:
- Reset: hold rst=0 with random in_valid/in_data.
  - Required: out_valid=0, out_last=0, out_idx=0, out_data=0, in_ready=1.
  - After release, no output until the first accept.
- Single frame: lane i = 32'h0001_0000+i, out_ready=1.
  - Required: 16 consecutive beats 32'h00010000..32'h0001000F, out_idx 0..15, out_last only on the 16th.
  - out_valid=0 on the next cycle.
- Sustained input, three frames A/B/C with in_valid held high:
  - A accepted at edge 0, B at edge 1.
  - in_ready=0 from cycle 2 until A's last beat. C is accepted at edge 17.
  - Required: 48 gap-free beats in order A, B, C.
- Backpressure: drop out_ready for 5 cycles at idx 7.
  - Required: out_idx=7 and out_data=lane 7 held.
  - Resume gives idx 8; total 16 beats, none lost or repeated.
- Simultaneous accept and release with cnt=1: new frame presented during the last beat.
  - Required: cnt stays 1, the next cycle shows the new frame's lane 0, no bubble.
- Mid-frame abort: assert rst=0 asynchronously at idx 9 (repeat using clr=1).
  - Required: outputs at reset values immediately (clr: next edge).
  - A new frame then emits from idx 0 with its own data; no old lanes appear.

Source files
------------

// File: rtl/fas_pkg.sv
// Shared FAS definitions: frame geometry, lane type and the lane-slicing helper
// used by both the serial-to-parallel and parallel-to-serial stages.
package fas_pkg;
  localparam int FAS_N     = 16;
  localparam int FAS_W     = 32;
  localparam int FAS_IDX_W = $clog2(FAS_N);

  typedef struct packed signed {
    logic signed [FAS_W/2-1:0] re;
    logic signed [FAS_W/2-1:0] im;
  } fas_lane_t;

  function automatic fas_lane_t fas_lane(input logic [FAS_N*FAS_W-1:0] frame,
                                         input logic [FAS_IDX_W-1:0]   i);
    return frame[int'(i)*FAS_W +: FAS_W];
  endfunction
endpackage

// File: rtl/fas_pts_frame_buf.sv
// One N-lane frame register: full-width load, lane read mux by index.
// Loads in one edge; cleared by async reset or synchronous clear.
module fas_pts_frame_buf
  import fas_pkg::*;
#(
  parameter int N  = FAS_N,
  parameter int W  = FAS_W,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          ld_i,
  input  logic [N*W-1:0] wr_dat_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [W-1:0]  rd_dat_o
);
  logic [N*W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (clr_i)     mem_d = '0;
    else if (ld_i) mem_d = wr_dat_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '0;
    else      mem_q <= mem_d;
  end

  assign rd_dat_o = mem_q[int'(rd_idx_i)*W +: W];
endmodule

// File: rtl/fas_pts.sv
// Ping-pong parallel-to-serial: one N-lane frame in per handshake, one lane out per cycle.
// Lane 0 appears the cycle after accept; out_ready low freezes the lane; in_ready is cnt<2.
module fas_pts
  import fas_pkg::*;
#(
  parameter int N = FAS_N,
  parameter int W = FAS_W,
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [IW-1:0]  out_idx,
  output logic           out_last
);
  logic [1:0]    cnt_q, cnt_d;
  logic          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          accept, beat, rel, last_lane;
  logic [W-1:0]  rd_dat [2];

  for (genvar b = 0; b < 2; b++) begin : g_buf
    fas_pts_frame_buf #(.N(N), .W(W)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clr),
      .ld_i     (accept && (wptr_q == 1'(b))),
      .wr_dat_i (in_data),
      .rd_idx_i (idx_q),
      .rd_dat_o (rd_dat[b])
    );
  end

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign beat      = out_valid & out_ready;
  assign last_lane = (idx_q == IW'(N-1));
  assign rel       = beat & last_lane;
  assign out_data  = rd_dat[rptr_q];
  assign out_idx   = idx_q;
  assign out_last  = out_valid & last_lane;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    if (accept) wptr_d = ~wptr_q;
    if (beat)   idx_d  = last_lane ? '0 : idx_q + 1'b1;
    if (rel)    rptr_d = ~rptr_q;
    // Accept and release in the same cycle leave the occupancy unchanged.
    case ({accept, rel})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (clr) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      idx_d  = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      idx_q  <= idx_d;
    end
  end
endmodule

// File: tb/tb_fas_pts.sv
// Bench for fas_pts: frame-queue reference model checked every cycle, plus
// table-driven and hand-written corner sequences.
module tb_fas_pts;
  import fas_pkg::*;
  localparam int N  = FAS_N;
  localparam int W  = FAS_W;
  localparam int IW = FAS_IDX_W;
  typedef logic [N*W-1:0] frame_t;

  typedef struct {
    bit          iv;
    bit          ordy;
    bit          e_rdy;
    bit          e_vld;
    int          e_idx;
    bit          e_last;
    logic [31:0] e_dat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  frame_t        in_data = '0;
  logic          in_ready, out_valid, out_last;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_idx;

  frame_t mq[$];
  int     midx = 0;
  int     n_chk = 0;
  int     n_pass = 0;

  always #5 clk = ~clk;

  fas_pts dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  function automatic frame_t mkframe(input logic [31:0] base);
    frame_t f;
    for (int i = 0; i < N; i++) f[i*W +: W] = base + 32'(i);
    return f;
  endfunction

  function automatic frame_t rndframe();
    frame_t f;
    for (int i = 0; i < N; i++) f[i*W +: W] = $urandom;
    return f;
  endfunction

  function automatic logic [31:0] mlane();
    frame_t    f = mq[0];
    fas_lane_t l = fas_lane(f, midx[IW-1:0]);
    return l;
  endfunction

  // Compare against the frame-queue model, advance one clock, update the model.
  task automatic cyc();
    bit     acc, bt;
    frame_t f;
    acc = in_valid && (mq.size() < 2);
    bt  = out_ready && (mq.size() != 0);
    f   = in_data;
    chk("m_in_ready",  32'(in_ready),  32'(mq.size() < 2));
    chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_out_idx",   32'(out_idx),   32'(midx));
    chk("m_out_last",  32'(out_last),  32'((mq.size() != 0) && (midx == N-1)));
    if (mq.size() != 0) chk("m_out_data", out_data, mlane());
    @(posedge clk); #1;
    if (!rst || clr) begin
      mq.delete();
      midx = 0;
    end else begin
      if (bt) begin
        if (midx == N-1) begin
          mq.delete(0);
          midx = 0;
        end else midx++;
      end
      if (acc) mq.push_back(f);
    end
  endtask

  task automatic drain_chk(input string tag, input logic [31:0] base);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk({tag, "_idx"},  32'(out_idx), 32'(i));
      chk({tag, "_data"}, out_data, base + 32'(i));
      cyc();
    end
    chk({tag, "_end_vld"}, 32'(out_valid), 32'(0));
  endtask

  task automatic wait_idx(input string tag, input int target);
    for (int k = 0; k < 40 && !(out_valid && out_idx == IW'(target)); k++) cyc();
    chk({tag, "_reached"}, 32'(out_idx), 32'(target));
  endtask

  initial begin
    vec_t        tv[18];
    logic [31:0] bases[3];
    logic [31:0] beats[$];
    logic [31:0] seen[$];
    int          acc_n, c_edge, first_c, last_c;
    bit          stalled;

    // Single-frame vectors
    tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'h0};
    for (int r = 1; r <= N; r++)
      tv[r] = '{1'b0, 1'b1, 1'b1, 1'b1, r-1, (r == N), 32'h0001_0000 + 32'(r-1)};
    tv[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'h0};

    // Reset held with random input activity
    for (int k = 0; k < 4; k++) begin
      in_valid  = 1'($urandom);
      in_data   = rndframe();
      out_ready = 1'b1;
      @(negedge clk);
      chk("rst_vld",  32'(out_valid), 32'(0));
      chk("rst_last", 32'(out_last),  32'(0));
      chk("rst_idx",  32'(out_idx),   32'(0));
      chk("rst_data", out_data,       32'(0));
      chk("rst_rdy",  32'(in_ready),  32'(1));
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) cyc();
    chk("post_rst_vld", 32'(out_valid), 32'(0));

    // Single frame, table-driven
    in_data = mkframe(32'h0001_0000);
    for (int r = 0; r < 18; r++) begin
      in_valid  = tv[r].iv;
      out_ready = tv[r].ordy;
      chk("sf_rdy",  32'(in_ready),  32'(tv[r].e_rdy));
      chk("sf_vld",  32'(out_valid), 32'(tv[r].e_vld));
      chk("sf_idx",  32'(out_idx),   32'(tv[r].e_idx));
      chk("sf_last", 32'(out_last),  32'(tv[r].e_last));
      if (tv[r].e_vld) chk("sf_data", out_data, tv[r].e_dat);
      cyc();
    end

    // Sustained A/B/C with in_valid held high
    bases = '{32'hA000_0000, 32'hB000_0000, 32'hC000_0000};
    acc_n = 0; c_edge = -1; first_c = -1; last_c = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 53; c++) begin
      bit a;
      in_valid = (acc_n < 3);
      if (acc_n < 3) in_data = mkframe(bases[acc_n]);
      if (c <= 17) chk("abc_rdy", 32'(in_ready), 32'(!(c >= 2 && c <= 16)));
      if (out_valid && out_ready) begin
        beats.push_back(out_data);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      a = in_valid && in_ready;
      cyc();
      if (a) begin
        acc_n++;
        if (acc_n == 3) c_edge = c;
      end
    end
    in_valid = 1'b0;
    chk("abc_c_edge", 32'(c_edge), 32'(17));
    chk("abc_nbeats", 32'(beats.size()), 32'(48));
    chk("abc_first",  32'(first_c), 32'(1));
    chk("abc_last",   32'(last_c), 32'(48));
    for (int i = 0; i < 48 && i < beats.size(); i++)
      chk("abc_beat", beats[i], bases[i/16] + 32'(i % 16));

    // Backpressure at idx 7
    in_valid = 1'b1; in_data = mkframe(32'h5000_0000); out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    stalled = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!stalled && out_valid && out_idx == IW'(7)) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          chk("bp_idx",  32'(out_idx), 32'(7));
          chk("bp_data", out_data, 32'h5000_0007);
          cyc();
        end
        stalled = 1'b1;
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) seen.push_back(out_data);
      cyc();
    end
    chk("bp_stalled", 32'(stalled), 32'(1));
    chk("bp_nbeats",  32'(seen.size()), 32'(16));
    for (int i = 0; i < 16 && i < seen.size(); i++) chk("bp_beat", seen[i], 32'h5000_0000 + 32'(i));

    // Accept and release in the same cycle
    in_valid = 1'b1; in_data = mkframe(32'h6000_0000);
    cyc();
    in_valid = 1'b0;
    wait_idx("sim", N-1);
    in_valid = 1'b1; in_data = mkframe(32'h7000_0000);
    chk("sim_rdy", 32'(in_ready), 32'(1));
    cyc();
    in_valid = 1'b0;
    chk("sim_rdy_after", 32'(in_ready), 32'(1));
    chk("sim_vld_after", 32'(out_valid), 32'(1));
    drain_chk("sim_y", 32'h7000_0000);

    // Async reset at idx 9
    in_valid = 1'b1; in_data = mkframe(32'h8000_0000);
    cyc();
    in_valid = 1'b0;
    wait_idx("arst", 9);
    #2 rst = 1'b0;
    #1;
    chk("arst_vld",  32'(out_valid), 32'(0));
    chk("arst_last", 32'(out_last),  32'(0));
    chk("arst_idx",  32'(out_idx),   32'(0));
    chk("arst_data", out_data,       32'(0));
    chk("arst_rdy",  32'(in_ready),  32'(1));
    mq.delete(); midx = 0;
    cyc();
    rst = 1'b1;
    in_valid = 1'b1; in_data = mkframe(32'h9000_0000);
    cyc();
    in_valid = 1'b0;
    drain_chk("arst_new", 32'h9000_0000);

    // Synchronous clear at idx 9, with a competing frame offered
    in_valid = 1'b1; in_data = mkframe(32'hC100_0000);
    cyc();
    in_valid = 1'b0;
    wait_idx("clr", 9);
    clr = 1'b1; in_valid = 1'b1; in_data = rndframe();
    cyc();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_vld",  32'(out_valid), 32'(0));
    chk("clr_last", 32'(out_last),  32'(0));
    chk("clr_idx",  32'(out_idx),   32'(0));
    chk("clr_data", out_data,       32'(0));
    chk("clr_rdy",  32'(in_ready),  32'(1));
    in_valid = 1'b1; in_data = mkframe(32'hD000_0000);
    cyc();
    in_valid = 1'b0;
    drain_chk("clr_new", 32'hD000_0000);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = rndframe();
      clr       = ($urandom_range(0, 99) == 0);
      cyc();
    end
    clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
